// File: rtl/spi_reg_pkg.sv
// Shared constants, frame layout and controller state encoding for the
// SPI register-write controller that programs the PWM peripheral.
package spi_reg_pkg;

    localparam int unsigned FRAME_BITS = 16;
    localparam int unsigned ADDR_W     = 7;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned BIT_CNT_W  = 4;

    localparam logic RW_WRITE = 1'b1;

    localparam logic [ADDR_W-1:0] ADDR_EN_OUT_7_0  = 7'h00;
    localparam logic [ADDR_W-1:0] ADDR_EN_OUT_15_8 = 7'h01;
    localparam logic [ADDR_W-1:0] ADDR_EN_PWM_7_0  = 7'h02;
    localparam logic [ADDR_W-1:0] ADDR_EN_PWM_15_8 = 7'h03;
    localparam logic [ADDR_W-1:0] ADDR_PWM_DUTY    = 7'h04;

    typedef struct packed {
        logic              rw;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } spi_frame_t;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT_HI,
        SHIFT_LO,
        GAP
    } spi_ctl_state_t;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period divider: while run is high, tick pulses once every CLK_DIV clk cycles.
module spi_clk_div #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic tick
);

    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CNT_W-1:0] cnt;

    assign tick = run && (cnt == CNT_W'(CLK_DIV - 1));

    // Restart from zero whenever idle so every phase gets a full CLK_DIV cycles.
    always_ff @(posedge clk) begin
        if (!rst_n || !run || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/spi_reg_controller.sv
// SPI mode-0 write-only initiator: one {1, addr[6:0], data[7:0]} frame per
// accepted command, MSB first, followed by a guaranteed nCS-high gap.
module spi_reg_controller #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [6:0] cmd_addr,
    input  logic [7:0] cmd_data,
    output logic       busy,
    output logic       done,
    output logic       sclk,
    output logic       ncs,
    output logic       copi
);

    import spi_reg_pkg::*;

    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(FRAME_BITS - 1);

    spi_ctl_state_t        state, state_n;
    logic [FRAME_BITS-1:0] shreg, shreg_n;
    logic [BIT_CNT_W-1:0]  bit_cnt, bit_cnt_n;
    logic                  sclk_n, ncs_n, copi_n, done_n;
    logic                  tick, run, accept;
    spi_frame_t            cmd_frame;

    assign cmd_ready = (state == IDLE);
    assign busy      = !cmd_ready;
    assign accept    = cmd_valid && cmd_ready;
    assign run       = (state != IDLE);
    assign cmd_frame = '{rw: RW_WRITE, addr: cmd_addr, data: cmd_data};

    spi_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (run),
        .tick  (tick)
    );

    // Next-state, datapath and output decode; pins are registered from state_n.
    always_comb begin
        state_n   = state;
        shreg_n   = shreg;
        bit_cnt_n = bit_cnt;
        copi_n    = copi;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_n   = SETUP;
                    shreg_n   = FRAME_BITS'(cmd_frame);
                    bit_cnt_n = '0;
                    copi_n    = cmd_frame.rw;
                end
            end
            SETUP: begin
                if (tick) state_n = SHIFT_HI;
            end
            SHIFT_HI: begin
                // COPI only moves on the falling SCLK edge.
                if (tick) begin
                    state_n = SHIFT_LO;
                    shreg_n = {shreg[FRAME_BITS-2:0], 1'b0};
                    copi_n  = shreg[FRAME_BITS-2];
                end
            end
            SHIFT_LO: begin
                if (tick) begin
                    if (bit_cnt == LAST_BIT) begin
                        state_n = GAP;
                        copi_n  = 1'b0;
                    end else begin
                        state_n   = SHIFT_HI;
                        bit_cnt_n = bit_cnt + BIT_CNT_W'(1);
                    end
                end
            end
            GAP: begin
                if (tick) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        sclk_n = (state_n == SHIFT_HI);
        ncs_n  = !(state_n inside {SETUP, SHIFT_HI, SHIFT_LO});
        done_n = (state == SHIFT_LO) && (state_n == GAP);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            sclk    <= 1'b0;
            ncs     <= 1'b1;
            copi    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            shreg   <= shreg_n;
            bit_cnt <= bit_cnt_n;
            sclk    <= sclk_n;
            ncs     <= ncs_n;
            copi    <= copi_n;
            done    <= done_n;
        end
    end

endmodule

// File: tb/tb_spi_reg_controller.sv
// Directed bench for spi_reg_controller: a CLK_DIV=4 instance under pin
// monitoring and a CLK_DIV=1 instance driving a behavioural register peripheral.
module tb_spi_reg_controller;

    localparam int unsigned BUDGET = 2000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [6:0] cmd_addr = '0;
    logic [7:0] cmd_data = '0;
    logic       cmd_ready, busy, done, sclk, ncs, copi;

    logic       cmd_valid1 = 1'b0;
    logic [6:0] cmd_addr1 = '0;
    logic [7:0] cmd_data1 = '0;
    logic       cmd_ready1, busy1, done1, sclk1, ncs1, copi1;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    spi_reg_controller #(.CLK_DIV(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .busy(busy), .done(done),
        .sclk(sclk), .ncs(ncs), .copi(copi)
    );

    spi_reg_controller #(.CLK_DIV(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
        .cmd_addr(cmd_addr1), .cmd_data(cmd_data1), .busy(busy1), .done(done1),
        .sclk(sclk1), .ncs(ncs1), .copi(copi1)
    );

    // Pin monitor for u_dut, sampled mid-cycle on the falling clk edge.
    logic        prev_ncs = 1'b1;
    logic        prev_sclk = 1'b0;
    logic [15:0] mon_frame = '0;
    logic [15:0] frame_log [0:31];
    int mon_bits = 0, mon_low = 0, hi_cnt = 0;
    int last_bits = 0, last_low = 0, last_hi = 0, last_ready_lat = 0;
    int frames = 0, dones = 0, accepts = 0, edge_viol = 0, stray = 0;
    bit track_ready = 1'b0;

    always @(negedge clk) begin
        if (cmd_valid === 1'b1 && cmd_ready === 1'b1) accepts++;
        if (done === 1'b1) dones++;
        if (ncs !== prev_ncs && sclk !== 1'b0) edge_viol++;
        if (sclk === 1'b1 && prev_sclk !== 1'b1) begin
            if (ncs === 1'b0) begin
                mon_frame = {mon_frame[14:0], copi};
                mon_bits++;
            end else begin
                stray++;
            end
        end
        if (ncs === 1'b0) begin
            if (prev_ncs !== 1'b0) begin
                last_hi = hi_cnt;
                mon_low = 0;
            end
            mon_low++;
        end else begin
            if (track_ready && cmd_ready === 1'b1) begin
                last_ready_lat = hi_cnt;
                track_ready = 1'b0;
            end
            if (prev_ncs === 1'b0) begin
                frame_log[frames & 31] = mon_frame;
                last_bits = mon_bits;
                last_low  = mon_low;
                frames++;
                mon_bits  = 0;
                mon_frame = '0;
                hi_cnt    = 0;
                track_ready = 1'b1;
            end
            hi_cnt++;
        end
        prev_ncs  = ncs;
        prev_sclk = sclk;
    end

    // Register-file peripheral on u_dut1: samples COPI on rising SCLK.
    logic [7:0]  periph_regs [0:127];
    logic [15:0] p_sh = '0;
    int p_bits = 0, p_writes = 0;

    always @(posedge sclk1) begin
        if (ncs1 === 1'b0) begin
            p_sh = {p_sh[14:0], copi1};
            p_bits++;
        end
    end

    always @(posedge ncs1) begin
        if (p_bits == 16 && p_sh[15] === 1'b1) begin
            periph_regs[p_sh[14:8]] = p_sh[7:0];
            p_writes++;
        end
        p_bits = 0;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (cmd_ready !== 1'b1 && n < BUDGET) begin step(); n++; end
        if (n >= BUDGET) begin checks++; $display("FAIL wait_ready: timeout after %0d clks", n); end
    endtask

    task automatic wait_frames(input int target);
        int n = 0;
        while (frames < target && n < BUDGET) begin step(); n++; end
        if (n >= BUDGET) begin checks++; $display("FAIL wait_frames: frames=%0d want %0d", frames, target); end
    endtask

    task automatic send(input logic [6:0] a, input logic [7:0] d);
        wait_ready();
        cmd_valid = 1'b1; cmd_addr = a; cmd_data = d;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic check_reset_pins(input string tag);
        checks++; if (ncs !== 1'b1) $display("FAIL %s_ncs: got %b want 1", tag, ncs); else passed++;
        checks++; if (sclk !== 1'b0) $display("FAIL %s_sclk: got %b want 0", tag, sclk); else passed++;
        checks++; if (copi !== 1'b0) $display("FAIL %s_copi: got %b want 0", tag, copi); else passed++;
        checks++; if (done !== 1'b0) $display("FAIL %s_done: got %b want 0", tag, done); else passed++;
        checks++; if (cmd_ready !== 1'b1) $display("FAIL %s_ready: got %b want 1", tag, cmd_ready); else passed++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin step(); check_reset_pins("por"); end
        rst_n = 1'b1;
        repeat (3) step();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin step(); check_reset_pins("idle_rst"); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single_frame();
        int f0 = frames, d0 = dones;
        send(7'h04, 8'h80);
        wait_frames(f0 + 1);
        wait_ready();
        step();
        checks++; if (frame_log[f0 & 31] !== 16'h8480) $display("FAIL single_frame: got %h want 8480", frame_log[f0 & 31]); else passed++;
        checks++; if (last_bits != 16) $display("FAIL single_bits: got %0d want 16", last_bits); else passed++;
        checks++; if (last_low != 132) $display("FAIL single_ncs_low: got %0d want 132", last_low); else passed++;
        checks++; if (dones - d0 != 1) $display("FAIL single_done: got %0d pulses want 1", dones - d0); else passed++;
        checks++; if (last_ready_lat != 4) $display("FAIL single_ready_lat: got %0d want 4", last_ready_lat); else passed++;
    endtask

    task automatic test_back_to_back();
        int f0 = frames, d0 = dones, a0 = accepts;
        wait_ready();
        cmd_valid = 1'b1; cmd_addr = 7'h00; cmd_data = 8'hFF;
        step();
        cmd_addr = 7'h01; cmd_data = 8'h0F;
        wait_ready();
        step();
        cmd_valid = 1'b0;
        wait_frames(f0 + 2);
        wait_ready();
        step();
        checks++; if (frame_log[f0 & 31] !== 16'h80FF) $display("FAIL b2b_frame0: got %h want 80ff", frame_log[f0 & 31]); else passed++;
        checks++; if (frame_log[(f0 + 1) & 31] !== 16'h810F) $display("FAIL b2b_frame1: got %h want 810f", frame_log[(f0 + 1) & 31]); else passed++;
        checks++; if (dones - d0 != 2) $display("FAIL b2b_done: got %0d pulses want 2", dones - d0); else passed++;
        checks++; if (last_hi < 4) $display("FAIL b2b_ncs_high: got %0d want >=4", last_hi); else passed++;
        checks++; if (accepts - a0 != 2) $display("FAIL b2b_accepts: got %0d want 2", accepts - a0); else passed++;
    endtask

    task automatic test_input_hold();
        int f0 = frames, a0 = accepts, n = 0;
        send(7'h02, 8'hA5);
        while (frames == f0 && n < BUDGET) begin
            cmd_valid = 1'($urandom);
            cmd_addr  = 7'($urandom);
            cmd_data  = 8'($urandom);
            step();
            n++;
        end
        cmd_valid = 1'b0;
        if (n >= BUDGET) begin checks++; $display("FAIL hold_timeout: frame never completed"); end
        wait_ready();
        step();
        checks++; if (frame_log[f0 & 31] !== 16'h82A5) $display("FAIL hold_frame: got %h want 82a5", frame_log[f0 & 31]); else passed++;
        checks++; if (accepts - a0 != 1) $display("FAIL hold_accepts: got %0d want 1", accepts - a0); else passed++;
        checks++; if (last_bits != 16) $display("FAIL hold_bits: got %0d want 16", last_bits); else passed++;
    endtask

    task automatic test_reset_mid_frame();
        int f0 = frames, d0, n = 0;
        send(7'h01, 8'h23);
        while (mon_bits < 5 && n < BUDGET) begin step(); n++; end
        if (n >= BUDGET) begin checks++; $display("FAIL midrst_timeout: only %0d sclk rises", mon_bits); end
        d0 = dones;
        rst_n = 1'b0;
        step();
        check_reset_pins("midrst");
        rst_n = 1'b1;
        repeat (10) step();
        checks++; if (dones != d0) $display("FAIL midrst_done: got %0d pulses want 0", dones - d0); else passed++;
        checks++; if (last_bits != 5) $display("FAIL midrst_bits: got %0d want 5", last_bits); else passed++;
        f0 = frames;
        send(7'h03, 8'h3C);
        wait_frames(f0 + 1);
        wait_ready();
        step();
        checks++; if (frame_log[f0 & 31] !== 16'h833C) $display("FAIL midrst_frame: got %h want 833c", frame_log[f0 & 31]); else passed++;
        checks++; if (last_bits != 16) $display("FAIL midrst_fresh_bits: got %0d want 16", last_bits); else passed++;
        checks++; if (last_low != 132) $display("FAIL midrst_ncs_low: got %0d want 132", last_low); else passed++;
    endtask

    task automatic send1(input logic [6:0] a, input logic [7:0] d);
        int n = 0;
        while (cmd_ready1 !== 1'b1 && n < BUDGET) begin step(); n++; end
        if (n >= BUDGET) begin checks++; $display("FAIL loop_ready: timeout"); end
        cmd_valid1 = 1'b1; cmd_addr1 = a; cmd_data1 = d;
        step();
        cmd_valid1 = 1'b0;
    endtask

    task automatic test_loopback();
        int w0 = p_writes;
        send1(7'h00, 8'hFF);
        send1(7'h04, 8'h80);
        repeat (50) step();
        checks++; if (periph_regs[0] !== 8'hFF) $display("FAIL loop_en_out: got %h want ff", periph_regs[0]); else passed++;
        checks++; if (periph_regs[4] !== 8'h80) $display("FAIL loop_pwm_duty: got %h want 80", periph_regs[4]); else passed++;
        checks++; if (p_writes - w0 != 2) $display("FAIL loop_writes: got %0d want 2", p_writes - w0); else passed++;
    endtask

    task automatic test_protocol();
        checks++; if (edge_viol != 0) $display("FAIL proto_sclk_at_ncs_edge: got %0d want 0", edge_viol); else passed++;
        checks++; if (stray != 0) $display("FAIL proto_stray_sclk: got %0d want 0", stray); else passed++;
    endtask

    initial begin
        step();
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_input_hold();
        test_reset_mid_frame();
        test_loopback();
        test_protocol();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
